// File: rtl/seq_gen.sv
// seq_gen -- iterative generator for a two-term additive recurrence.
//
// Computes a(n) of a(k) = a(k-1) + a(k-2) with a(0)=s0 and a(1)=s1, one
// addition per clock, using a three-state FSMD (IDLE -> OP -> DONE -> IDLE).
// With s0=0, s1=1 this is Fibonacci; with s0=2, s1=1 it is Lucas.
//
// Parameters
//   W    result / seed width in bits (>= 2)
//   NW   index width in bits (>= 1)
//   SAT  0: additions wrap modulo 2^W, 1: additions saturate at 2^W-1
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   start      request a computation (sampled only while ready=1)
//   abort      cancel an in-progress computation (sampled only in OP)
//   i          index n of the requested term
//   s0, s1     seed terms a(0), a(1)
//   ready      idle, able to accept start
//   done_tick  one-cycle pulse, f holds the result
//   f          result a(n), driven straight from the t1 register
//   ovf        sticky: some addition of the current/last run carried out
module seq_gen #(
  parameter int W   = 20,
  parameter int NW  = 5,
  parameter int SAT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [NW-1:0] i,
  input  logic [W-1:0]  s0,
  input  logic [W-1:0]  s1,
  output logic          ready,
  output logic          done_tick,
  output logic [W-1:0]  f,
  output logic          ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OP   = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [W-1:0]  t0_reg, t0_next;
  logic [W-1:0]  t1_reg, t1_next;
  logic [NW-1:0] n_reg, n_next;
  logic          ovf_reg, ovf_next;
  logic [W:0]    sum;

  // Full-width sum of the two held terms; bit W is the carry out.
  function automatic logic [W:0] add_wide(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Fold a carried-out sum back to W bits: clamp or wrap.
  function automatic logic [W-1:0] sat_wrap(input logic [W:0] s);
    if (s[W] && (SAT != 0))
      return '1;
    else
      return s[W-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      t0_reg    <= '0;
      t1_reg    <= '0;
      n_reg     <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      t0_reg    <= t0_next;
      t1_reg    <= t1_next;
      n_reg     <= n_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    t0_next    = t0_reg;
    t1_next    = t1_reg;
    n_next     = n_reg;
    ovf_next   = ovf_reg;
    sum        = add_wide(t0_reg, t1_reg);
    case (state_reg)
      IDLE: begin
        // abort is deliberately not looked at here, so start always wins.
        if (start) begin
          t0_next    = s0;
          t1_next    = s1;
          n_next     = i;
          ovf_next   = 1'b0;
          state_next = OP;
        end
      end
      OP: begin
        if (abort) begin
          state_next = IDLE;
        end else if (n_reg == '0) begin
          // a(0) requested: the answer is the first seed.
          t1_next    = t0_reg;
          state_next = DONE;
        end else if (n_reg == NW'(1)) begin
          state_next = DONE;
        end else begin
          // Slide the window one term forward; n counts down to 1, so the
          // largest index never wraps.
          t0_next = t1_reg;
          t1_next = sat_wrap(sum);
          n_next  = n_reg - NW'(1);
          if (sum[W])
            ovf_next = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ready     = (state_reg == IDLE);
  assign done_tick = (state_reg == DONE);
  assign f         = t1_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen -- self-checking bench for seq_gen.
//
// Three instances share stimulus: W=20 wrap, W=8 wrap, W=8 saturate. The
// 8-bit instances see the low byte of the seeds. Results are compared to a
// queue-based model of the recurrence and to hand-derived constants.
module tb_seq_gen;
  localparam int NW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [NW-1:0] i;
  logic [19:0]   s0, s1;

  logic        ready20, done20, ovf20;
  logic [19:0] f20;
  logic        ready8, done8, ovf8;
  logic [7:0]  f8;
  logic        ready8s, done8s, ovf8s;
  logic [7:0]  f8s;

  int checks = 0;
  int errors = 0;

  int     wid[3]  = '{20, 8, 8};
  bit     satv[3] = '{1'b0, 1'b0, 1'b1};

  // Observations of the last run.
  int     done_cyc, ready_cyc, overlap, done_count;
  longint fd[3], fr[3];
  bit     od[3], orr[3];

  always #5 clk = ~clk;

  seq_gen #(.W(20), .NW(NW), .SAT(0)) u_w20 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .i(i),
    .s0(s0), .s1(s1), .ready(ready20), .done_tick(done20), .f(f20), .ovf(ovf20));

  seq_gen #(.W(8), .NW(NW), .SAT(0)) u_w8 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .i(i),
    .s0(s0[7:0]), .s1(s1[7:0]), .ready(ready8), .done_tick(done8), .f(f8), .ovf(ovf8));

  seq_gen #(.W(8), .NW(NW), .SAT(1)) u_w8s (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .i(i),
    .s0(s0[7:0]), .s1(s1[7:0]), .ready(ready8s), .done_tick(done8s), .f(f8s), .ovf(ovf8s));

  function automatic longint get_f(input int k);
    case (k)
      0:       return longint'(f20);
      1:       return longint'(f8);
      default: return longint'(f8s);
    endcase
  endfunction

  function automatic bit get_ovf(input int k);
    case (k)
      0:       return ovf20;
      1:       return ovf8;
      default: return ovf8s;
    endcase
  endfunction

  // Reference: build the sequence term by term in a queue.
  task automatic model(input longint a0, input longint a1, input int n, input int w,
                       input bit sat, output longint val, output bit ov);
    longint lim;
    longint a[$];
    longint s;
    lim = (longint'(1) << w) - 1;
    a.push_back(a0 & lim);
    a.push_back(a1 & lim);
    ov = 1'b0;
    for (int k = 2; k <= n; k++) begin
      s = a[k-1] + a[k-2];
      if (s > lim) begin
        ov = 1'b1;
        s  = sat ? lim : (s & lim);
      end
      a.push_back(s);
    end
    val = a[n];
  endtask

  // Entered and left #1 after a rising edge. The accepting edge is cycle 0's
  // end; cycle c is observed #1 after edge c-1. Inputs are scrambled after
  // acceptance so any late sampling shows up as a wrong result.
  task automatic do_run(input int iv, input longint a0, input longint a1,
                        input int abort_c, input int busy_c, input bit abort0);
    i = NW'(iv); s0 = 20'(a0); s1 = 20'(a1); start = 1'b1; abort = abort0;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    done_cyc = 0; ready_cyc = 0; overlap = 0; done_count = 0;
    for (int c = 1; c <= 40 && ready_cyc == 0; c++) begin
      i = NW'($urandom); s0 = 20'($urandom); s1 = 20'($urandom);
      if (done20 && ready20) overlap++;
      if (done20) begin
        done_count++;
        if (done_cyc == 0) done_cyc = c;
        for (int k = 0; k < 3; k++) begin fd[k] = get_f(k); od[k] = get_ovf(k); end
      end
      if (ready20) begin
        ready_cyc = c;
        for (int k = 0; k < 3; k++) begin fr[k] = get_f(k); orr[k] = get_ovf(k); end
      end
      abort = (c == abort_c);
      start = (c == busy_c);
      if (ready_cyc == 0) begin @(posedge clk); #1; end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0; i = '0; s0 = '0; s1 = '0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (ready20 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready20); end
    checks++; if (done20 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done20); end
    checks++; if (f20 !== 20'd0) begin errors++; $display("FAIL reset_f: got %0d expected 0", f20); end
    checks++; if (ovf20 !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf20); end
    reset = 1'b0;
    #1;
    checks++; if (ready20 !== 1'b1 || f20 !== 20'd0) begin
      errors++; $display("FAIL post_reset: got ready=%b f=%0d expected ready=1 f=0", ready20, f20);
    end
    #3;
    @(posedge clk); #1;
  endtask

  // Directed Fibonacci / Lucas / boundary / overflow table, run back to back.
  task automatic test_directed;
    int t_i[6]   = '{10, 5, 0, 1, 14, 5};
    int t_a0[6]  = '{0, 2, 2, 2, 0, 0};
    int t_a1[6]  = '{1, 1, 1, 1, 1, 1};
    int t_e20[6] = '{55, 11, 2, 1, 377, 5};
    int t_e8[6]  = '{55, 11, 2, 1, 121, 5};
    int t_e8s[6] = '{55, 11, 2, 1, 255, 5};
    bit t_o8[6]  = '{0, 0, 0, 0, 1, 0};
    int ed;
    for (int r = 0; r < 6; r++) begin
      do_run(t_i[r], longint'(t_a0[r]), longint'(t_a1[r]), -1, -1, 1'b0);
      ed = ((t_i[r] < 1) ? 1 : t_i[r]) + 1;
      checks++; if (done_cyc != ed) begin errors++; $display("FAIL dir%0d_done_cycle: got %0d expected %0d", r, done_cyc, ed); end
      checks++; if (ready_cyc != ed + 1) begin errors++; $display("FAIL dir%0d_ready_cycle: got %0d expected %0d", r, ready_cyc, ed + 1); end
      checks++; if (fd[0] != longint'(t_e20[r])) begin errors++; $display("FAIL dir%0d_f_w20: got %0d expected %0d", r, fd[0], t_e20[r]); end
      checks++; if (fd[1] != longint'(t_e8[r])) begin errors++; $display("FAIL dir%0d_f_w8: got %0d expected %0d", r, fd[1], t_e8[r]); end
      checks++; if (fd[2] != longint'(t_e8s[r])) begin errors++; $display("FAIL dir%0d_f_w8sat: got %0d expected %0d", r, fd[2], t_e8s[r]); end
      checks++; if (od[0] !== 1'b0) begin errors++; $display("FAIL dir%0d_ovf_w20: got %b expected 0", r, od[0]); end
      checks++; if (od[1] !== t_o8[r] || od[2] !== t_o8[r]) begin
        errors++; $display("FAIL dir%0d_ovf_w8: got %b/%b expected %b", r, od[1], od[2], t_o8[r]);
      end
      checks++; if (fr[0] != fd[0] || orr[1] !== od[1] || done_count != 1 || overlap != 0) begin
        errors++; $display("FAIL dir%0d_hold: got f=%0d ovf=%b pulses=%0d overlap=%0d expected f=%0d ovf=%b pulses=1 overlap=0",
                           r, fr[0], orr[1], done_count, overlap, fd[0], od[1]);
      end
    end
  endtask

  task automatic test_random;
    int     iv, ed;
    longint a0, a1, ev;
    bit     eo;
    for (int r = 0; r < 24; r++) begin
      iv = (r == 0) ? 31 : (r == 1) ? 0 : int'($urandom_range(0, 31));
      a0 = longint'($urandom) & 64'hFFFFF;
      a1 = longint'($urandom) & 64'hFFFFF;
      do_run(iv, a0, a1, -1, -1, 1'b0);
      ed = ((iv < 1) ? 1 : iv) + 1;
      checks++; if (done_cyc != ed || ready_cyc != ed + 1 || overlap != 0) begin
        errors++; $display("FAIL rnd%0d_timing: got done=%0d ready=%0d overlap=%0d expected done=%0d ready=%0d overlap=0",
                           r, done_cyc, ready_cyc, overlap, ed, ed + 1);
      end
      for (int k = 0; k < 3; k++) begin
        model(a0, a1, iv, wid[k], satv[k], ev, eo);
        checks++; if (fd[k] != ev || od[k] !== eo) begin
          errors++; $display("FAIL rnd%0d_dut%0d i=%0d: got f=%0d ovf=%b expected f=%0d ovf=%b", r, k, iv, fd[k], od[k], ev, eo);
        end
      end
    end
  endtask

  task automatic test_abort;
    do_run(20, 64'd0, 64'd1, 4, -1, 1'b0);
    checks++; if (done_count != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_count); end
    checks++; if (ready_cyc != 5) begin errors++; $display("FAIL abort_ready_cycle: got %0d expected 5", ready_cyc); end
    // Three additions completed before the abort edge: t1 = a(4) = 3.
    checks++; if (fr[0] != 64'd3 || orr[0] !== 1'b0) begin
      errors++; $display("FAIL abort_hold: got f=%0d ovf=%b expected f=3 ovf=0", fr[0], orr[0]);
    end
    do_run(7, 64'd0, 64'd1, -1, -1, 1'b0);
    checks++; if (fd[0] != 64'd13 || done_cyc != 8) begin
      errors++; $display("FAIL abort_rerun: got f=%0d done=%0d expected f=13 done=8", fd[0], done_cyc);
    end
  endtask

  task automatic test_back_to_back;
    // Start pulsed mid-run with a scrambled index must be ignored.
    do_run(10, 64'd0, 64'd1, -1, 3, 1'b0);
    checks++; if (fd[0] != 64'd55 || done_cyc != 11 || ready_cyc != 12) begin
      errors++; $display("FAIL busy_start: got f=%0d done=%0d ready=%0d expected f=55 done=11 ready=12", fd[0], done_cyc, ready_cyc);
    end
    // start and abort together in IDLE: run is accepted.
    do_run(6, 64'd2, 64'd1, -1, -1, 1'b1);
    checks++; if (fd[0] != 64'd18 || done_cyc != 7) begin
      errors++; $display("FAIL start_with_abort: got f=%0d done=%0d expected f=18 done=7", fd[0], done_cyc);
    end
  endtask

  task automatic test_reset_mid_op;
    // Low bytes 200+100 carry in the 8-bit instances on the first addition.
    i = NW'(20); s0 = 20'd200; s1 = 20'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (ovf8 !== 1'b1 || ready20 !== 1'b0) begin
      errors++; $display("FAIL midop_precond: got ovf8=%b ready=%b expected ovf8=1 ready=0", ovf8, ready20);
    end
    reset = 1'b1;
    #1;
    checks++; if (f20 !== 20'd0 || ovf8 !== 1'b0 || ready20 !== 1'b1 || done20 !== 1'b0) begin
      errors++; $display("FAIL midop_reset: got f=%0d ovf8=%b ready=%b done=%b expected f=0 ovf8=0 ready=1 done=0",
                         f20, ovf8, ready20, done20);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (done20 !== 1'b0 || ready20 !== 1'b1) begin
      errors++; $display("FAIL midop_after: got done=%b ready=%b expected done=0 ready=1", done20, ready20);
    end
    do_run(10, 64'd0, 64'd1, -1, -1, 1'b0);
    checks++; if (fd[0] != 64'd55 || done_cyc != 11) begin
      errors++; $display("FAIL midop_rerun: got f=%0d done=%0d expected f=55 done=11", fd[0], done_cyc);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_abort;
    test_back_to_back;
    test_reset_mid_op;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 The block SHALL have parameter W, default 20, the result and seed width in bits (W >= 2).
REQ-002 The block SHALL have parameter NW, default 5, the index width in bits (NW >= 1).
REQ-003 The block SHALL have parameter SAT, default 0: 0 selects modulo-2^W wrap, 1 selects saturation at 2^W-1.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a computation; sampled only while ready=1.
REQ-007 abort  input  1  cancel an in-progress computation; sampled only in state OP.
REQ-008 i  input  NW  index n of the requested term.
REQ-009 s0  input  W  seed term a(0).
REQ-010 s1  input  W  seed term a(1).
REQ-011 ready  output  1  block idle and able to accept start.
REQ-012 done_tick  output  1  one-cycle pulse: result valid.
REQ-013 f  output  W  result a(n); registered.
REQ-014 ovf  output  1  sticky flag: an addition in the current or last computation exceeded 2^W-1.

Function
REQ-015 The block SHALL compute a(n) of the recurrence a(k) = a(k-1) + a(k-2) with a(0)=s0 and a(1)=s1 (s0=0, s1=1 gives Fibonacci; s0=2, s1=1 gives Lucas).
REQ-016 The block SHALL implement a three-state FSMD with states IDLE, OP and DONE; any unused encoding SHALL return to IDLE.
REQ-017 IDLE: ready=1; on start=1 the block SHALL load t0<=s0, t1<=s1, n<=i and ovf<=0, and go to OP.
REQ-018 IDLE without start: all registers SHALL hold.
REQ-019 If start and abort are both high in IDLE, start SHALL be accepted and abort ignored.
REQ-020 OP, when abort=1: the block SHALL go to IDLE next cycle with no done_tick; t0, t1 and ovf SHALL hold; abort SHALL take priority over every other OP action.
REQ-021 OP, when n==0: t1<=t0, then DONE.
REQ-022 OP, when n==1: t1 SHALL hold, then DONE.
REQ-023 OP, when n>=2: sum = t0+t1 computed W+1 bits wide; t0<=t1; n<=n-1; stay in OP.
REQ-024 On carry (sum bit W = 1): ovf<=1; t1<=sum[W-1:0] if SAT=0, or t1<=2^W-1 if SAT=1.
REQ-025 Without carry: t1<=sum[W-1:0].
REQ-026 ovf SHALL stay set until the next accepted start or reset.
REQ-027 DONE: done_tick=1 for exactly one cycle, ready=0, then IDLE.
REQ-028 Latency: with the start-accepting edge as cycle 0, done_tick SHALL be high in cycle max(i,1)+1, and ready SHALL be high again in cycle max(i,1)+2.
REQ-029 start asserted while ready=0 SHALL be ignored; s0, s1 and i SHALL be sampled only on the accepting edge.
REQ-030 f SHALL equal t1 at all times and SHALL hold its value in IDLE until the next accepted start.
REQ-031 ready and done_tick SHALL be combinational decodes of state only and SHALL never be high simultaneously.
REQ-032 i = 2^NW-1 SHALL complete normally without wrap of n.

Reset
REQ-033 reset=1 SHALL force state IDLE and t0=0, t1=0, n=0, ovf=0, asynchronously and in any state, including mid-OP.
REQ-034 During and after reset: ready=1, done_tick=0, f=0, ovf=0.
REQ-035 The first start after reset deassertion SHALL be accepted on the next rising edge.

Verification
REQ-036 Fibonacci: W=20, s0=0, s1=1, i=10, start pulse -> done_tick in cycle 11, f=55, ovf=0, ready in cycle 12.
REQ-037 Lucas and boundaries: s0=2, s1=1, i=5 -> f=11; i=0 -> f=2 with done_tick in cycle 2; i=1 -> f=1 with done_tick in cycle 2.
REQ-038 Overflow: W=8, s0=0, s1=1, i=14 -> SAT=0 gives f=121, ovf=1; SAT=1 gives f=255, ovf=1; a following run with i=5 -> f=5, ovf=0.
REQ-039 Abort: i=20, abort in cycle 4 -> no done_tick, ready in cycle 5, start is accepted again and the next run result is correct.
REQ-040 Busy start: start re-asserted in OP with a different i -> ignored and the original result returned; start and abort together in IDLE -> run accepted.
REQ-041 Reset mid-OP in cycle 3 -> f=0, ovf=0, ready=1 immediately, no done_tick; a subsequent run is correct.
